// File: rtl/hack_io_pkg.sv
// hack_io_pkg: shared types, defaults and helpers for the bit-serial input path
// Contents:
//   state_t            - deserializer FSM state (COLLECT / FULL)
//   DEFAULT_WORD_WIDTH - default assembled word width
//   even_parity        - XOR-reduction of up to 16 data bits
package hack_io_pkg;
  typedef enum logic {COLLECT, FULL} state_t;
  localparam int DEFAULT_WORD_WIDTH = 8;
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/word_hold_reg.sv
// word_hold_reg: output register slice of serial_to_word (word, valid flag, non-zero flag)
// Optional macro: SERIAL_TO_WORD_PARITY_EN (adds the registered parity-error flag)
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_load     - capture i_word this edge (word_valid set)
//   i_consume  - consumer takes the current word this edge
//   i_word     - word to capture
//   i_perr     - parity error of i_word (parity build only)
//   o_word     - held word, stable until the next load
//   o_valid    - o_word holds an unconsumed word
//   o_nz       - registered OR-reduction of o_word
//   o_perr     - registered parity error of o_word (parity build only)
module word_hold_reg
  import hack_io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_consume,
  input  logic [WIDTH-1:0] i_word,
`ifdef SERIAL_TO_WORD_PARITY_EN
  input  logic             i_perr,
  output logic             o_perr,
`endif
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_nz
);
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_nz;
`ifdef SERIAL_TO_WORD_PARITY_EN
  logic             r_perr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perr <= 1'b0;
    else if (i_load) r_perr <= i_perr;
  end
  assign o_perr = r_perr;
`endif
  // A load wins over a same-edge consume, so back-to-back words keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_nz    <= 1'b0;
    end else begin
      if (i_load) begin
        r_word <= i_word;
        r_nz   <= |i_word;
      end
      r_valid <= i_load | (r_valid & ~i_consume);
    end
  end
  assign o_word  = r_word;
  assign o_valid = r_valid;
  assign o_nz    = r_nz;
endmodule

// File: rtl/serial_to_word.sv
// serial_to_word: bit-serial to WIDTH-bit word deserializer with valid/ready word output
// Optional macro: SERIAL_TO_WORD_PARITY_EN (frames gain a trailing even-parity bit; adds par_err)
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   clr        - synchronous discard of the partial or held word (output register untouched)
//   bit_in     - serial data bit, accepted when bit_valid && bit_ready
//   bit_valid  - bit_in is valid this cycle
//   bit_ready  - block can accept a bit this cycle
//   word_out   - assembled word (registered)
//   word_valid - word_out holds an unconsumed word
//   word_ready - consumer accepts word_out this cycle
//   word_nz    - registered OR-reduction of word_out
//   par_err    - registered parity mismatch of word_out (parity build only)
module serial_to_word
  import hack_io_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_nz
`ifdef SERIAL_TO_WORD_PARITY_EN
  ,
  output logic             par_err
`endif
);
`ifdef SERIAL_TO_WORD_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] NDATA = CW'(WIDTH);
  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nx;
  logic [WIDTH-1:0] w_word;
  logic             w_acc;
  logic             w_last;
  logic             w_room;
  logic             w_cons;
  logic             w_load;
  assign w_sh_nx = (LSB_FIRST != 0) ? {bit_in, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], bit_in};
`ifdef SERIAL_TO_WORD_PARITY_EN
  logic r_perr;
  logic w_perr_now;
  logic w_perr;
  // The final bit of a frame is the parity bit; the data is already complete in r_sh.
  assign w_word     = r_sh;
  assign w_perr_now = even_parity(16'(r_sh)) ^ bit_in;
  assign w_perr     = (r_state == FULL) ? r_perr : w_perr_now;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perr <= 1'b0;
    else if (w_last) r_perr <= w_perr_now;
  end
`else
  // In COLLECT the word is forwarded straight from the shifter including the bit on the wire.
  assign w_word = (r_state == FULL) ? r_sh : w_sh_nx;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == COLLECT) w_next = (w_last && !w_room) ? FULL : COLLECT;
    else w_next = (clr || w_cons) ? COLLECT : FULL;
  end
  always_comb begin
    bit_ready = (r_state == COLLECT);
    w_acc     = bit_valid && bit_ready && !clr;
    w_last    = w_acc && (r_cnt == LAST);
    w_cons    = word_valid && word_ready;
    w_room    = !word_valid || word_ready;
    w_load    = clr ? 1'b0 : (r_state == FULL) ? w_cons : (w_last && w_room);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (clr || (r_state == FULL && w_next == COLLECT)) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (r_cnt < NDATA) r_sh <= w_sh_nx;
    end
  end
  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_consume (word_ready),
    .i_word    (w_word),
`ifdef SERIAL_TO_WORD_PARITY_EN
    .i_perr    (w_perr),
    .o_perr    (par_err),
`endif
    .o_word    (word_out),
    .o_valid   (word_valid),
    .o_nz      (word_nz)
  );
endmodule

// File: tb/tb_serial_to_word.sv
// tb_serial_to_word: randomized and directed check of serial_to_word (LSB- and MSB-first instances)
module tb_serial_to_word;
  localparam int W = 8;
`ifdef SERIAL_TO_WORD_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic clr = 0;
  logic bit_in = 0;
  logic bit_valid = 0;
  logic word_ready = 0;
  logic ra, rb, va, vb, nza, nzb;
  logic [W-1:0] oa, ob;
`ifdef SERIAL_TO_WORD_PARITY_EN
  logic pa, pb;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  serial_to_word #(.WIDTH(W), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(ra), .word_out(oa), .word_valid(va), .word_ready(word_ready), .word_nz(nza)
`ifdef SERIAL_TO_WORD_PARITY_EN
    , .par_err(pa)
`endif
  );
  serial_to_word #(.WIDTH(W), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(rb), .word_out(ob), .word_valid(vb), .word_ready(word_ready), .word_nz(nzb)
`ifdef SERIAL_TO_WORD_PARITY_EN
    , .par_err(pb)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a queue of received bits, one pending-word slot and the output slot.
  bit q[$];
  bit m_full = 0;
  bit m_valid = 0;
  bit m_nv;
  logic [W-1:0] m_out_a = 0, m_out_b = 0, m_held_a = 0, m_held_b = 0, m_wa, m_wb;
  bit m_perr = 0, m_held_perr = 0, m_pe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_full = 0; m_valid = 0; m_out_a = 0; m_out_b = 0; m_perr = 0;
    end else begin
      m_nv = m_valid && !word_ready;
      if (clr) begin
        q.delete();
        m_full = 0;
      end else if (m_full) begin
        if (m_valid && word_ready) begin
          m_out_a = m_held_a; m_out_b = m_held_b; m_perr = m_held_perr;
          m_full = 0; m_nv = 1;
        end
      end else if (bit_valid) begin
        q.push_back(bit_in);
        if (q.size() == FRAME) begin
          m_wa = 0; m_wb = 0;
          for (int i = 0; i < W; i++) begin
            m_wa[i] = q[i];
            m_wb[W-1-i] = q[i];
          end
          m_pe = (FRAME > W) ? ((^m_wa) != q[FRAME-1]) : 1'b0;
          q.delete();
          if (!m_valid || word_ready) begin
            m_out_a = m_wa; m_out_b = m_wb; m_perr = m_pe; m_nv = 1;
          end else begin
            m_held_a = m_wa; m_held_b = m_wb; m_held_perr = m_pe; m_full = 1;
          end
        end
      end
      m_valid = m_nv;
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("bit_ready_a", ra, !m_full);
      chk("bit_ready_b", rb, !m_full);
      chk("word_valid_a", va, m_valid);
      chk("word_valid_b", vb, m_valid);
      chk("word_out_a", oa, m_out_a);
      chk("word_out_b", ob, m_out_b);
      chk("word_nz_a", nza, |m_out_a);
      chk("word_nz_b", nzb, |m_out_b);
`ifdef SERIAL_TO_WORD_PARITY_EN
      chk("par_err_a", pa, m_perr);
      chk("par_err_b", pb, m_perr);
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    logic acc;
    int tries;
    tries = 0;
    bit_in = b;
    bit_valid = 1;
    do begin
      acc = ra;
      step();
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk("send_bit_timeout", 0, 1);
  endtask
  // Sends w bit 0 first, so the LSB-first instance assembles w and the MSB-first one its reverse.
  task automatic send_word(input logic [W-1:0] w, input bit flip);
    for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef SERIAL_TO_WORD_PARITY_EN
    send_bit((^w) ^ flip);
`endif
    bit_valid = 0;
  endtask
  initial begin
    step();
    step();
    rst_n = 1;
    chk_on = 1;
    step();
    chk("reset_valid", va, 0);
    chk("reset_out", oa, 0);
    chk("reset_ready", ra, 1);
    word_ready = 1;
    send_word(8'h4D, 0);
    chk("t1_out_a", oa, 8'h4D);
    chk("t1_out_b", ob, 8'hB2);
    chk("t1_valid", va, 1);
    chk("t1_nz", nza, 1);
    send_word(8'h00, 0);
    chk("t2_out", oa, 8'h00);
    chk("t2_valid", va, 1);
    chk("t2_nz", nza, 0);
    send_word(8'h01, 0);
    chk("t2_msb_out", ob, 8'h80);
    step();
    word_ready = 0;
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    chk("t3_ready_low", ra, 0);
    chk("t3_hold_a5", oa, 8'hA5);
    step();
    chk("t3_stable_a5", oa, 8'hA5);
    word_ready = 1;
    step();
    chk("t3_next_3c", oa, 8'h3C);
    chk("t3_valid_kept", va, 1);
    chk("t3_ready_back", ra, 1);
    step();
    chk("t3_drained", va, 0);
    chk("t3_out_kept", oa, 8'h3C);
    send_bit(1); send_bit(0); send_bit(1);
    bit_valid = 0;
    clr = 1;
    step();
    clr = 0;
    step();
    chk("t4_no_stray", va, 0);
    send_word(8'hFF, 0);
    chk("t4_ff", oa, 8'hFF);
    step();
    chk("t4_single", va, 0);
    word_ready = 0;
    send_word(8'h11, 0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bit_valid = 0;
    rst_n = 0;
    #1;
    chk("t5_rst_valid", va, 0);
    chk("t5_rst_out", oa, 0);
    chk("t5_rst_nz", nza, 0);
    step();
    rst_n = 1;
    word_ready = 1;
    send_word(8'h5A, 0);
    chk("t5_5a", oa, 8'h5A);
`ifdef SERIAL_TO_WORD_PARITY_EN
    send_word(8'h4D, 0);
    chk("par_ok", pa, 0);
    send_word(8'h4D, 1);
    chk("par_bad", pa, 1);
    chk("par_word", oa, 8'h4D);
`endif
    for (int c = 0; c < 3000; c++) begin
      bit_in     = 1'($urandom);
      bit_valid  = ($urandom_range(0, 9) < 7);
      word_ready = ($urandom_range(0, 9) < 5);
      clr        = ($urandom_range(0, 24) == 0);
      step();
    end
    bit_valid = 0;
    clr = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
